regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 44 ++++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 57 +++++
 tb/tb_regfile_wb_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and types for the write-back path.
// Optional same-cycle read bypass is enabled with REGFILE_WB_BYPASS_EN.
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int AW = 5;
    localparam int NREGS = 32;
    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] reg_data_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between requesters, the arbiter and the register file write port.
// REGFILE_WB_BYPASS_EN adds the read-bypass signals.
interface regfile_wb_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW = 5
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 we3;
    logic [AW-1:0]        wa3;
    logic [XLEN-1:0]      wd3;
    logic [IDW-1:0]       grant_id;
`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0]        ra1;
    logic [AW-1:0]        ra2;
    logic [XLEN-1:0]      rf_rd1;
    logic [XLEN-1:0]      rf_rd2;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;

    modport master (
        output req_valid, req_addr, req_data, ra1, ra2, rf_rd1, rf_rd2,
        input  req_ready, we3, wa3, wd3, grant_id, rd1, rd2
    );
    modport slave (
        input  req_valid, req_addr, req_data, ra1, ra2, rf_rd1, rf_rd2,
        output req_ready, we3, wa3, wd3, grant_id, rd1, rd2
    );
`else
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we3, wa3, wd3, grant_id
    );
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we3, wa3, wd3, grant_id
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: combinational one-hot grant searched from
// rr_ptr upward with wrap, pointer moves just past the winner.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(rr_ptr) + k) % N);
            if (!grant_any && valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file write port through one
// register stage. Optional read bypass of the pending write: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int AW = regfile_pkg::AW
) (
    input logic        clk,
    input logic        reset,
    regfile_wb_if.slave bus
);
    import regfile_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;
    logic            win_live;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (bus.req_valid),
        .grant     (bus.req_ready),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    assign win_addr = bus.req_addr[win_idx*AW +: AW];
    assign win_data = bus.req_data[win_idx*XLEN +: XLEN];
    // Writes to x0 are still granted and consumed, they just never reach the file.
    assign win_live = win_any && (win_addr != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.we3      <= 1'b0;
            bus.wa3      <= '0;
            bus.wd3      <= '0;
            bus.grant_id <= '0;
        end else begin
            bus.we3 <= win_live;
            if (win_live) begin
                bus.wa3      <= win_addr;
                bus.wd3      <= win_data;
                bus.grant_id <= win_idx;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the write sitting in the output stage to same-cycle readers.
    assign bus.rd1 = (bus.ra1 != AW'(ZERO_REG) && bus.we3 && bus.wa3 == bus.ra1) ? bus.wd3 : bus.rf_rd1;
    assign bus.rd2 = (bus.ra2 != AW'(ZERO_REG) && bus.we3 && bus.wa3 == bus.ra2) ? bus.wd3 : bus.rf_rd2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus random bench for regfile_wb_arbiter against a transaction-level model.
// Also exercises the read bypass when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_if #(.NREQ(N), .XLEN(XLEN), .AW(AW)) bus ();

    regfile_wb_arbiter #(.NREQ(N), .XLEN(XLEN), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;

    // Requester-side stimulus
    logic [N-1:0] vld;
    reg_addr_t    addr_q [N];
    reg_data_t    data_q [N];
    int           lastg;

    // Model: fairness pointer plus the write expected in the output stage
    int        mptr;
    logic      mwe;
    reg_addr_t mwa;
    reg_data_t mwd;
    int        mgid;
    bit        mknown;

    // Winner = valid requester closest to the pointer going upward with wrap.
    function automatic int winner();
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - mptr + N) % N;
            if (vld[i] && d < bestd) begin
                best = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]              = vld[i];
            bus.req_addr[i*AW +: AW]      = addr_q[i];
            bus.req_data[i*XLEN +: XLEN]  = data_q[i];
        end
`ifdef REGFILE_WB_BYPASS_EN
        bus.ra1    = ($urandom_range(0, 1) == 1) ? mwa : reg_addr_t'($urandom);
        bus.ra2    = ($urandom_range(0, 3) == 0) ? '0 : reg_addr_t'($urandom);
        bus.rf_rd1 = $urandom;
        bus.rf_rd2 = $urandom;
`endif
    endtask

    task automatic checkOutput();
        int g = winner();
        logic [N-1:0] er = '0;
        if (g >= 0) er[g] = 1'b1;
        cmp("req_ready", 64'(bus.req_ready), 64'(er));
        cmp("we3", 64'(bus.we3), 64'(mwe));
        if (mknown) begin
            cmp("wa3", 64'(bus.wa3), 64'(mwa));
            cmp("wd3", 64'(bus.wd3), 64'(mwd));
        end
        if (mwe) cmp("grant_id", 64'(bus.grant_id), 64'(mgid));
        cmp("rr_ptr", 64'(dut.u_arb.rr_ptr), 64'(mptr));
`ifdef REGFILE_WB_BYPASS_EN
        cmp("rd1", 64'(bus.rd1), 64'((bus.ra1 != 0 && mwe && mwa == bus.ra1) ? mwd : bus.rf_rd1));
        cmp("rd2", 64'(bus.rd2), 64'((bus.ra2 != 0 && mwe && mwa == bus.ra2) ? mwd : bus.rf_rd2));
`endif
    endtask

    task automatic modelEdge();
        int g = winner();
        lastg = g;
        if (reset) begin
            mptr = 0; mwe = 1'b0; mwa = '0; mwd = '0; mgid = 0; mknown = 1'b1;
        end else if (g >= 0) begin
            mptr = (g + 1) % N;
            if (addr_q[g] != 0) begin
                mwe = 1'b1; mwa = addr_q[g]; mwd = data_q[g]; mgid = g; mknown = 1'b1;
            end else begin
                mwe = 1'b0; mknown = 1'b0;
            end
        end else begin
            mwe = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        vld = '0;
        lastg = -1;
        for (int i = 0; i < N; i++) begin
            addr_q[i] = '0;
            data_q[i] = '0;
        end
        mptr = 0; mwe = 1'b0; mwa = '0; mwd = '0; mgid = 0; mknown = 1'b1;
        applyStimulus();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 1'b0;
        $display("[TB] idle after reset");
        repeat (10) cycle();

        $display("[TB] single write");
        vld = 3'b001; addr_q[0] = 5'd5; data_q[0] = 32'hDEADBEEF;
        applyStimulus();
        cycle();
        vld = '0;
        applyStimulus();
`ifdef REGFILE_WB_BYPASS_EN
        bus.ra1 = 5'd5;
        bus.ra2 = 5'd0;
`endif
        cycle();

        $display("[TB] round robin");
        vld = 3'b111;
        for (int i = 0; i < N; i++) begin
            addr_q[i] = reg_addr_t'(i + 1);
            data_q[i] = $urandom;
        end
        repeat (6) begin
            applyStimulus();
            cycle();
        end
        vld = '0;
        applyStimulus();
        cycle();

        $display("[TB] write to x0");
        vld = 3'b010; addr_q[1] = 5'd0; data_q[1] = 32'h1234;
        applyStimulus();
        cycle();
        vld = '0;
        applyStimulus();
        cycle();
        cycle();

        $display("[TB] reset mid-operation");
        vld = 3'b100; addr_q[2] = 5'd9; data_q[2] = $urandom;
        applyStimulus();
        cycle();
        vld = '0; reset = 1'b1;
        applyStimulus();
        cycle();
        reset = 1'b0;
        applyStimulus();
        repeat (3) cycle();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] || lastg == i) begin
                    vld[i]    = ($urandom_range(0, 2) != 0);
                    addr_q[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : reg_addr_t'($urandom);
                    data_q[i] = $urandom;
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            applyStimulus();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
